fetch_pipe_ctrl: RTL and testbench
==================================

Name: fetch_pipe_ctrl

Overview:
- Sequences the front-end pipeline registers regIF1, regIF2 and regD by generating their stall and bubble controls.
- Owns the I-cache request/response handshake.
- Absorbs a response that arrives while the backend is stalled into a 1-entry skid buffer.
- Discards in-flight responses after a redirect and pulses the PC generator for advance and redirect loads.

Parameters:
- PC_W, 64, width of PC and redirect target.
- INSTR_W, 32, instruction width.
- TIMEOUT_CYCLES, 1023, response wait count at which timeout_err sets; must be at least 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- icache_req_valid  out  1  fetch request valid.
- icache_req_ready  in  1  I-cache accepts request.
- icache_resp_valid  in  1  response beat; one per accepted request.
- icache_resp_instr  in  INSTR_W  response instruction.
- backend_stall  in  1  regD cannot advance this cycle.
- redirect_valid  in  1  flush and redirect, single-cycle pulse.
- redirect_pc  in  PC_W  redirect target.
- pc_advance  out  1  pulse: PC generator increments.
- pc_load  out  1  pulse: PC generator loads pc_load_target.
- pc_load_target  out  PC_W  equals redirect_pc.
- if1_valid  out  1  if1_instr is valid for regIF1 this cycle.
- if1_instr  out  INSTR_W  instruction to regIF1.
- regIF1_stall, regIF2_stall, regD_stall  out  1 each  hold the register.
- regIF1_bubble, regIF2_bubble, regD_bubble  out  1 each  load zeros; bubble beats stall inside the register.
- timeout_err  out  1  sticky error flag.

Behaviour:
- States: RUN, WAIT_RESP, DROP_RESP. Additional registers:
  - buf_valid and buf_instr (skid buffer).
  - wait_cnt, saturating, width clog2(TIMEOUT_CYCLES+1).
  - timeout_err.
- Async reset (rst_n low):
  - State RUN, buf_valid=0, wait_cnt=0, timeout_err=0.
  - All outputs 0 while rst_n is low.
- Priority order: redirect_valid > backend_stall > normal flow.
- icache_req_valid = (state==RUN) & ~buf_valid & ~backend_stall & ~redirect_valid.
- pc_advance = icache_req_valid & icache_req_ready. On that handshake: RUN -> WAIT_RESP, wait_cnt=0.
- Redirect cycle:
  - regIF1/regIF2/regD_bubble=1, all stalls 0, if1_valid=0.
  - pc_load=1, pc_load_target=redirect_pc.
  - buf_valid cleared.
  - WAIT_RESP without resp that cycle -> DROP_RESP. WAIT_RESP with resp that cycle -> RUN, response discarded. RUN stays RUN.
  - A redirect while in DROP_RESP stays in DROP_RESP; exactly one response is still discarded.
- backend_stall=1 without redirect:
  - All three stalls 1, all bubbles 0, if1_valid=0.
  - WAIT_RESP with resp that cycle: buf_instr<=resp, buf_valid<=1, state -> RUN.
- Normal flow (no stall, no redirect):
  - buf_valid=1: if1_valid=1, if1_instr=buf_instr, buf_valid<=0, regIF1_stall=0. No request this cycle.
  - WAIT_RESP with resp: if1_valid=1, if1_instr=icache_resp_instr, state -> RUN. The response passes through combinationally, zero added latency.
  - Otherwise: if1_valid=0, regIF1_bubble=1.
  - regIF2 and regD have no stall and no bubble; they advance.
- DROP_RESP: icache_req_valid=0. On resp: discard, -> RUN. backend_stall still drives the stalls. Any resp_valid in RUN is ignored.
- Timeout:
  - wait_cnt increments each cycle in WAIT_RESP or DROP_RESP and saturates.
  - Reaching TIMEOUT_CYCLES sets timeout_err. It stays set until reset; the FSM is unaffected.
- Invariants:
  - At most one request outstanding.
  - Buffer never overflows, because no request is issued while buf_valid=1.
  - if1_valid and regIF1_bubble are never both 1.

Decomposition:
- Shared front-end package holds:
  - State enum type fetch_state_t (RUN, WAIT_RESP, DROP_RESP).
  - PC_W and INSTR_W defaults.
- One sub-module, fetch_skid_buf: 1-entry instruction holding register with load/clear/valid, async active-low reset.

Test Plan:
1. Reset release, req_ready=1, response 2 cycles after request with instr 0x00000013 -> pc_advance one cycle; if1_valid=1, if1_instr=0x00000013 on the resp cycle; regIF1_bubble=1 during the wait cycle.
2. backend_stall=1 on the resp cycle (instr 0x12345678), released 3 cycles later -> all stalls=1 for 3 cycles. if1_valid=1 with 0x12345678 on the release cycle; icache_req_valid=1 the following cycle.
3. redirect_valid with redirect_pc=0x80001000 while in WAIT_RESP, resp 2 cycles later -> all bubbles=1 and pc_load=1 with target 0x80001000 for one cycle. That resp gives if1_valid=0; the next request issues on the cycle after the resp.
4. redirect_valid on the same cycle as resp_valid in WAIT_RESP -> resp discarded, state RUN, icache_req_valid=1 next cycle.
5. Redirect while buf_valid=1 under backend_stall -> buffer cleared; no stale if1_valid after the stall releases.
6. TIMEOUT_CYCLES=8, resp never returns -> timeout_err=1 after 8 wait cycles and stays 1. A later resp returns the FSM to RUN with timeout_err still 1.

Source files
------------

// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared front-end definitions for the fetch pipeline controller.
package fetch_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_RESP = 2'd1,
    DROP_RESP = 2'd2
  } fetch_state_t;

  localparam int DEF_PC_W    = 64;
  localparam int DEF_INSTR_W = 32;

endpackage

// File: rtl/fetch_pipe_ctrl_if.sv
// I-cache request/response handshake between the fetch controller (master)
// and the instruction cache (slave).
interface fetch_pipe_ctrl_if
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W
);

  logic               icache_req_valid;
  logic               icache_req_ready;
  logic               icache_resp_valid;
  logic [INSTR_W-1:0] icache_resp_instr;

  modport master (
    output icache_req_valid,
    input  icache_req_ready,
    input  icache_resp_valid,
    input  icache_resp_instr
  );

  modport slave (
    input  icache_req_valid,
    output icache_req_ready,
    output icache_resp_valid,
    output icache_resp_instr
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instruction holding register; catches a response that arrives
// while the backend is stalled.
module fetch_skid_buf
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] din,
  output logic               valid,
  output logic [INSTR_W-1:0] dout
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Front-end fetch controller: drives stall/bubble for regIF1/regIF2/regD,
// owns the I-cache handshake, and drops responses orphaned by a redirect.
module fetch_pipe_ctrl
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter int PC_W           = DEF_PC_W,
  parameter int INSTR_W        = DEF_INSTR_W,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_pipe_ctrl_if.master  ic,
  input  logic               backend_stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               pc_advance,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_target,
  output logic               if1_valid,
  output logic [INSTR_W-1:0] if1_instr,
  output logic               regIF1_stall,
  output logic               regIF2_stall,
  output logic               regD_stall,
  output logic               regIF1_bubble,
  output logic               regIF2_bubble,
  output logic               regD_bubble,
  output logic               timeout_err
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  fetch_state_t       state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  logic               buf_load, buf_clear, buf_valid;
  logic [INSTR_W-1:0] buf_instr;
  logic               req_valid;
  logic               resp_in_wait, resp_in_drop, counting;

  fetch_skid_buf #(.INSTR_W(INSTR_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (ic.icache_resp_instr),
    .valid (buf_valid),
    .dout  (buf_instr)
  );

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_err_d  = timeout_err_q;
    buf_load       = 1'b0;
    buf_clear      = 1'b0;
    req_valid      = 1'b0;
    pc_advance     = 1'b0;
    pc_load        = 1'b0;
    pc_load_target = '0;
    if1_valid      = 1'b0;
    if1_instr      = '0;
    regIF1_stall   = 1'b0;
    regIF2_stall   = 1'b0;
    regD_stall     = 1'b0;
    regIF1_bubble  = 1'b0;
    regIF2_bubble  = 1'b0;
    regD_bubble    = 1'b0;

    resp_in_wait = (state_q == WAIT_RESP) && ic.icache_resp_valid;
    resp_in_drop = (state_q == DROP_RESP) && ic.icache_resp_valid;
    counting     = (state_q == WAIT_RESP) || (state_q == DROP_RESP);

    if (counting) begin
      wait_cnt_d = sat_inc(wait_cnt_q);
      if (wait_cnt_d == CNT_MAX) timeout_err_d = 1'b1;
    end

    if (redirect_valid) begin
      regIF1_bubble  = 1'b1;
      regIF2_bubble  = 1'b1;
      regD_bubble    = 1'b1;
      pc_load        = 1'b1;
      pc_load_target = redirect_pc;
      buf_clear      = 1'b1;
      // An outstanding request becomes stale: drop its response when it lands.
      if (state_q == WAIT_RESP)      state_d = resp_in_wait ? RUN : DROP_RESP;
      else if (state_q == DROP_RESP) state_d = resp_in_drop ? RUN : DROP_RESP;
    end else if (backend_stall) begin
      regIF1_stall = 1'b1;
      regIF2_stall = 1'b1;
      regD_stall   = 1'b1;
      if (resp_in_wait) begin
        buf_load = 1'b1;
        state_d  = RUN;
      end else if (resp_in_drop) begin
        state_d = RUN;
      end
    end else if (buf_valid) begin
      if1_valid = 1'b1;
      if1_instr = buf_instr;
      buf_clear = 1'b1;
    end else if (resp_in_wait) begin
      if1_valid = 1'b1;
      if1_instr = ic.icache_resp_instr;
      state_d   = RUN;
    end else begin
      regIF1_bubble = 1'b1;
      if (resp_in_drop) state_d = RUN;
      if (state_q == RUN) begin
        req_valid = 1'b1;
        if (ic.icache_req_ready) begin
          pc_advance = 1'b1;
          state_d    = WAIT_RESP;
          wait_cnt_d = '0;
        end
      end
    end

    // Every output reads as zero while reset is held, regardless of inputs.
    if (!rst_n) begin
      req_valid      = 1'b0;
      pc_advance     = 1'b0;
      pc_load        = 1'b0;
      pc_load_target = '0;
      if1_valid      = 1'b0;
      if1_instr      = '0;
      regIF1_stall   = 1'b0;
      regIF2_stall   = 1'b0;
      regD_stall     = 1'b0;
      regIF1_bubble  = 1'b0;
      regIF2_bubble  = 1'b0;
      regD_bubble    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ic.icache_req_valid = req_valid;
  assign timeout_err         = timeout_err_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl with an instruction scoreboard on if1.
module tb_fetch_pipe_ctrl;
  import fetch_pipe_ctrl_pkg::*;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               backend_stall, redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               pc_advance, pc_load;
  logic [PC_W-1:0]    pc_load_target;
  logic               if1_valid;
  logic [INSTR_W-1:0] if1_instr;
  logic               regIF1_stall, regIF2_stall, regD_stall;
  logic               regIF1_bubble, regIF2_bubble, regD_bubble;
  logic               timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [INSTR_W-1:0] sb_q[$];

  fetch_pipe_ctrl_if #(.INSTR_W(INSTR_W)) ic ();

  fetch_pipe_ctrl #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic             (ic),
    .backend_stall  (backend_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_advance     (pc_advance),
    .pc_load        (pc_load),
    .pc_load_target (pc_load_target),
    .if1_valid      (if1_valid),
    .if1_instr      (if1_instr),
    .regIF1_stall   (regIF1_stall),
    .regIF2_stall   (regIF2_stall),
    .regD_stall     (regD_stall),
    .regIF1_bubble  (regIF1_bubble),
    .regIF2_bubble  (regIF2_bubble),
    .regD_bubble    (regD_bubble),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each delivered instruction must match the oldest expected one.
  task automatic mon();
    if (if1_valid === 1'b1) begin
      if (sb_q.size() == 0) chk("sb_unexpected_if1_valid", {63'd0, if1_valid}, 64'd0);
      else                  chk("sb_instr", {32'd0, if1_instr}, {32'd0, sb_q.pop_front()});
    end
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [INSTR_W-1:0] ri,
                     input logic st, input logic rd, input logic [PC_W-1:0] rpc);
    @(negedge clk);
    ic.icache_req_ready  = rdy;
    ic.icache_resp_valid = rv;
    ic.icache_resp_instr = ri;
    backend_stall        = st;
    redirect_valid       = rd;
    redirect_pc          = rpc;
    #1;
    mon();
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst_n                = 1'b0;
    ic.icache_req_ready  = 1'b1;
    ic.icache_resp_valid = 1'b0;
    ic.icache_resp_instr = '0;
    backend_stall        = 1'b0;
    redirect_valid       = 1'b1;
    redirect_pc          = 64'h1234;
    #2;
    chk("rst_req_valid", {63'd0, ic.icache_req_valid}, 64'd0);
    chk("rst_pc_load", {63'd0, pc_load}, 64'd0);
    chk("rst_load_target", pc_load_target, 64'd0);
    chk("rst_if1_bubble", {63'd0, regIF1_bubble}, 64'd0);
    chk("rst_d_bubble", {63'd0, regD_bubble}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_err}, 64'd0);

    // Release reset with the cache not ready: request held, no advance.
    @(negedge clk);
    rst_n               = 1'b1;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    ic.icache_req_ready = 1'b0;
    #1;
    chk("r0_req_valid", {63'd0, ic.icache_req_valid}, 64'd1);
    chk("r0_no_advance", {63'd0, pc_advance}, 64'd0);

    // 1: basic request / two-cycle response
    idle();
    chk("t1_req_valid", {63'd0, ic.icache_req_valid}, 64'd1);
    chk("t1_advance", {63'd0, pc_advance}, 64'd1);
    idle();
    chk("t1_wait_advance", {63'd0, pc_advance}, 64'd0);
    chk("t1_wait_bubble", {63'd0, regIF1_bubble}, 64'd1);
    chk("t1_wait_req", {63'd0, ic.icache_req_valid}, 64'd0);
    sb_q.push_back(32'h0000_0013);
    cyc(1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
    chk("t1_resp_valid", {63'd0, if1_valid}, 64'd1);
    chk("t1_resp_bubble", {63'd0, regIF1_bubble}, 64'd0);

    // 2: response lands under backend stall, released three cycles later
    idle();
    chk("t2_advance", {63'd0, pc_advance}, 64'd1);
    sb_q.push_back(32'h1234_5678);
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, '0);
    chk("t2_stalls_c0", {61'd0, regIF1_stall, regIF2_stall, regD_stall}, 64'd7);
    chk("t2_bubbles_c0", {61'd0, regIF1_bubble, regIF2_bubble, regD_bubble}, 64'd0);
    chk("t2_if1_c0", {63'd0, if1_valid}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
      chk("t2_stalls_hold", {61'd0, regIF1_stall, regIF2_stall, regD_stall}, 64'd7);
      chk("t2_req_hold", {63'd0, ic.icache_req_valid}, 64'd0);
    end
    idle();
    chk("t2_release_valid", {63'd0, if1_valid}, 64'd1);
    chk("t2_release_stall", {63'd0, regIF1_stall}, 64'd0);
    chk("t2_release_req", {63'd0, ic.icache_req_valid}, 64'd0);
    idle();
    chk("t2_next_req", {63'd0, ic.icache_req_valid}, 64'd1);
    chk("t2_next_adv", {63'd0, pc_advance}, 64'd1);

    // 3: redirect while waiting, orphaned response dropped
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 64'h8000_1000);
    chk("t3_bubbles", {61'd0, regIF1_bubble, regIF2_bubble, regD_bubble}, 64'd7);
    chk("t3_stalls", {61'd0, regIF1_stall, regIF2_stall, regD_stall}, 64'd0);
    chk("t3_pc_load", {63'd0, pc_load}, 64'd1);
    chk("t3_target", pc_load_target, 64'h8000_1000);
    chk("t3_if1", {63'd0, if1_valid}, 64'd0);
    idle();
    chk("t3_pc_load_pulse", {63'd0, pc_load}, 64'd0);
    chk("t3_drop_req", {63'd0, ic.icache_req_valid}, 64'd0);
    chk("t3_drop_if2_bubble", {63'd0, regIF2_bubble}, 64'd0);
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    chk("t3_drop_if1", {63'd0, if1_valid}, 64'd0);
    chk("t3_drop_req2", {63'd0, ic.icache_req_valid}, 64'd0);
    idle();
    chk("t3_reissue", {63'd0, ic.icache_req_valid}, 64'd1);

    // 4: redirect coinciding with the response
    cyc(1'b1, 1'b1, 32'hAAAA_5555, 1'b0, 1'b1, 64'h4000);
    chk("t4_if1", {63'd0, if1_valid}, 64'd0);
    chk("t4_pc_load", {63'd0, pc_load}, 64'd1);
    chk("t4_target", pc_load_target, 64'h4000);
    idle();
    chk("t4_next_req", {63'd0, ic.icache_req_valid}, 64'd1);

    // 5: redirect flushes a buffered instruction
    cyc(1'b1, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0, '0);
    chk("t5_buf_stall", {63'd0, regIF1_stall}, 64'd1);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 64'h9000);
    chk("t5_redir_stall", {63'd0, regIF1_stall}, 64'd0);
    chk("t5_redir_bubble", {63'd0, regIF1_bubble}, 64'd1);
    chk("t5_redir_load", {63'd0, pc_load}, 64'd1);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("t5_stall_again", {63'd0, regIF1_stall}, 64'd1);
    idle();
    chk("t5_no_stale", {63'd0, if1_valid}, 64'd0);
    chk("t5_req", {63'd0, ic.icache_req_valid}, 64'd1);
    chk("t5_timeout_clear", {63'd0, timeout_err}, 64'd0);

    // 6: response never returns; timeout after 8 wait cycles, sticky
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("t6_before_timeout", {63'd0, timeout_err}, 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t6_timeout_set", {63'd0, timeout_err}, 64'd1);
    end
    sb_q.push_back(32'h0000_0077);
    cyc(1'b1, 1'b1, 32'h0000_0077, 1'b0, 1'b0, '0);
    chk("t6_late_resp", {63'd0, if1_valid}, 64'd1);
    idle();
    chk("t6_run_req", {63'd0, ic.icache_req_valid}, 64'd1);
    chk("t6_sticky", {63'd0, timeout_err}, 64'd1);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
